// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR/trap sequencer: op encodings,
// CSR addresses, the ecall cause value, FSM states and request legality.
package csr_pkg;

  localparam logic [2:0] CSR_OP_RW    = 3'd0;
  localparam logic [2:0] CSR_OP_RS    = 3'd1;
  localparam logic [2:0] CSR_OP_RC    = 3'd2;
  localparam logic [2:0] CSR_OP_ECALL = 3'd3;
  localparam logic [2:0] CSR_OP_MRET  = 3'd4;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // Environment call from M-mode
  localparam logic [31:0] ECALL_CAUSE = 32'hb;

  typedef enum logic [2:0] {
    IDLE,
    CREAD,
    CWRITE,
    TEPC,
    TCAUSE,
    TVEC,
    RREAD,
    DONE
  } csr_state_e;

  // Only the four trap-handling CSRs are implemented
  function automatic logic csr_addr_legal(input logic [11:0] addr);
    return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) ||
           (addr == CSR_MEPC)    || (addr == CSR_MCAUSE);
  endfunction

  // CSR ops need a supported address; ecall/mret ignore the address field
  function automatic logic csr_req_legal(input logic [2:0] op, input logic [11:0] addr);
    logic legal;
    case (op)
      CSR_OP_RW, CSR_OP_RS, CSR_OP_RC: legal = csr_addr_legal(addr);
      CSR_OP_ECALL, CSR_OP_MRET:       legal = 1'b1;
      default:                         legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/csr_trap_ctrl.sv
// Sequences the CSR register-file ports for one csrrw/csrrs/csrrc/ecall/mret
// request at a time and returns the old CSR value or a PC redirect.
// After every response the unit spends one extra idle cycle with req_ready
// low, so consecutive requests are always separated by a bubble.
module csr_trap_ctrl
  import csr_pkg::*;
#(
  parameter int               XLEN        = 32,
  parameter logic [XLEN-1:0]  ECALL_CAUSE = XLEN'(csr_pkg::ECALL_CAUSE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [11:0]     req_csr_addr,
  input  logic [XLEN-1:0] req_src,
  input  logic            req_src_is_x0,
  input  logic [XLEN-1:0] req_pc,
  output logic [11:0]     r_csr_addr,
  output logic            r_csr_en,
  input  logic [XLEN-1:0] r_csr_data,
  output logic [11:0]     w_csr_addr,
  output logic [XLEN-1:0] w_csr_data,
  output logic            w_csr_en,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rd_data,
  output logic            resp_redirect,
  output logic [XLEN-1:0] resp_redirect_pc,
  output logic            resp_illegal
);

  csr_state_e      state_q, state_d;
  logic [2:0]      op_q;
  logic [11:0]     addr_q;
  logic [XLEN-1:0] src_q;
  logic            src_x0_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] data_q;
  logic            illegal_q;
  logic            bubble_q;
  logic            accept;
  logic            is_csr_op;
  logic [XLEN-1:0] new_val;

  assign accept    = req_valid && req_ready;
  assign is_csr_op = (op_q == CSR_OP_RW) || (op_q == CSR_OP_RS) || (op_q == CSR_OP_RC);

  // Read-modify-write result computed from the value latched in CREAD
  always_comb begin
    case (op_q)
      CSR_OP_RS: new_val = data_q | src_q;
      CSR_OP_RC: new_val = data_q & ~src_q;
      default:   new_val = src_q;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request capture, read-data latch and post-response bubble flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= '0;
      addr_q    <= '0;
      src_q     <= '0;
      src_x0_q  <= 1'b0;
      pc_q      <= '0;
      data_q    <= '0;
      illegal_q <= 1'b0;
      bubble_q  <= 1'b0;
    end else begin
      bubble_q <= (state_q == DONE);
      if (accept) begin
        op_q      <= req_op;
        addr_q    <= req_csr_addr;
        src_q     <= req_src;
        src_x0_q  <= req_src_is_x0;
        pc_q      <= req_pc;
        illegal_q <= !csr_req_legal(req_op, req_csr_addr);
      end
      if (r_csr_en) data_q <= r_csr_data;
    end
  end

  // Next-state selection for each request type
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!csr_req_legal(req_op, req_csr_addr)) state_d = DONE;
          else begin
            case (req_op)
              CSR_OP_ECALL: state_d = TEPC;
              CSR_OP_MRET:  state_d = RREAD;
              default:      state_d = CREAD;
            endcase
          end
        end
      end
      CREAD:   state_d = CWRITE;
      CWRITE:  state_d = DONE;
      TEPC:    state_d = TCAUSE;
      TCAUSE:  state_d = TVEC;
      TVEC:    state_d = DONE;
      RREAD:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Port drive per state; everything idles at zero when not enabled
  always_comb begin
    req_ready        = (state_q == IDLE) && !bubble_q;
    r_csr_en         = 1'b0;
    r_csr_addr       = '0;
    w_csr_en         = 1'b0;
    w_csr_addr       = '0;
    w_csr_data       = '0;
    resp_valid       = 1'b0;
    resp_rd_data     = '0;
    resp_redirect    = 1'b0;
    resp_redirect_pc = '0;
    resp_illegal     = 1'b0;
    case (state_q)
      CREAD: begin
        r_csr_en   = 1'b1;
        r_csr_addr = addr_q;
      end
      CWRITE: begin
        if ((op_q == CSR_OP_RW) || !src_x0_q) begin
          w_csr_en   = 1'b1;
          w_csr_addr = addr_q;
          w_csr_data = new_val;
        end
      end
      TEPC: begin
        w_csr_en   = 1'b1;
        w_csr_addr = CSR_MEPC;
        w_csr_data = pc_q;
      end
      TCAUSE: begin
        w_csr_en   = 1'b1;
        w_csr_addr = CSR_MCAUSE;
        w_csr_data = ECALL_CAUSE;
      end
      TVEC: begin
        r_csr_en   = 1'b1;
        r_csr_addr = CSR_MTVEC;
      end
      RREAD: begin
        r_csr_en   = 1'b1;
        r_csr_addr = CSR_MEPC;
      end
      DONE: begin
        resp_valid   = 1'b1;
        resp_illegal = illegal_q;
        if (!illegal_q) begin
          if (is_csr_op) resp_rd_data = data_q;
          else begin
            resp_redirect    = 1'b1;
            resp_redirect_pc = data_q;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl with a small CSR register-file model,
// write/read logging and a continuous port-exclusivity monitor.
module tb_csr_trap_ctrl;
  import csr_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [11:0]     req_csr_addr;
  logic [XLEN-1:0] req_src;
  logic            req_src_is_x0;
  logic [XLEN-1:0] req_pc;
  logic [11:0]     r_csr_addr;
  logic            r_csr_en;
  logic [XLEN-1:0] r_csr_data;
  logic [11:0]     w_csr_addr;
  logic [XLEN-1:0] w_csr_data;
  logic            w_csr_en;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rd_data;
  logic            resp_redirect;
  logic [XLEN-1:0] resp_redirect_pc;
  logic            resp_illegal;

  int checks = 0;
  int errors = 0;

  // Register-file model and activity logs
  logic [XLEN-1:0] rf_mstatus = '0;
  logic [XLEN-1:0] rf_mtvec   = '0;
  logic [XLEN-1:0] rf_mepc    = '0;
  logic [XLEN-1:0] rf_mcause  = '0;
  int              cyc        = 0;
  int              wr_total   = 0;
  int              rd_total   = 0;
  int              viol       = 0;
  logic [11:0]     wr_addr_log [16];
  logic [XLEN-1:0] wr_data_log [16];
  int              wr_cyc_log  [16];

  // Results of the most recent request
  int              got_lat;
  logic [XLEN-1:0] got_rd;
  logic            got_redir;
  logic [XLEN-1:0] got_pc;
  logic            got_illegal;
  int              wr_start;
  int              wr_n;
  int              rd_n;
  int              acc_cyc;

  always #5 clk = ~clk;

  csr_trap_ctrl #(.XLEN(XLEN), .ECALL_CAUSE(32'hb)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_csr_addr     (req_csr_addr),
    .req_src          (req_src),
    .req_src_is_x0    (req_src_is_x0),
    .req_pc           (req_pc),
    .r_csr_addr       (r_csr_addr),
    .r_csr_en         (r_csr_en),
    .r_csr_data       (r_csr_data),
    .w_csr_addr       (w_csr_addr),
    .w_csr_data       (w_csr_data),
    .w_csr_en         (w_csr_en),
    .resp_valid       (resp_valid),
    .resp_rd_data     (resp_rd_data),
    .resp_redirect    (resp_redirect),
    .resp_redirect_pc (resp_redirect_pc),
    .resp_illegal     (resp_illegal)
  );

  // Combinational register-file read port
  always_comb begin
    r_csr_data = '0;
    if (r_csr_en) begin
      case (r_csr_addr)
        CSR_MSTATUS: r_csr_data = rf_mstatus;
        CSR_MTVEC:   r_csr_data = rf_mtvec;
        CSR_MEPC:    r_csr_data = rf_mepc;
        CSR_MCAUSE:  r_csr_data = rf_mcause;
        default:     r_csr_data = '0;
      endcase
    end
  end

  // Clocked register-file write port with a write log
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (w_csr_en) begin
      case (w_csr_addr)
        CSR_MSTATUS: rf_mstatus <= w_csr_data;
        CSR_MTVEC:   rf_mtvec   <= w_csr_data;
        CSR_MEPC:    rf_mepc    <= w_csr_data;
        CSR_MCAUSE:  rf_mcause  <= w_csr_data;
        default: ;
      endcase
      wr_addr_log[wr_total % 16] <= w_csr_addr;
      wr_data_log[wr_total % 16] <= w_csr_data;
      wr_cyc_log[wr_total % 16]  <= cyc;
      wr_total <= wr_total + 1;
    end
  end

  // Read counting and port exclusivity / zero-when-idle monitor
  always @(negedge clk) begin
    if (r_csr_en) rd_total <= rd_total + 1;
    if ((r_csr_en && w_csr_en) || (!r_csr_en && r_csr_addr != 12'h0) ||
        (!w_csr_en && (w_csr_addr != 12'h0 || w_csr_data != '0)))
      viol <= viol + 1;
  end

  // Issue one request and collect its response; latency counts negedges after acceptance
  task automatic do_req(input logic [2:0] op, input logic [11:0] addr,
                        input logic [XLEN-1:0] src, input logic x0, input logic [XLEN-1:0] pc);
    int waited;
    got_lat = -1; got_rd = '0; got_redir = 1'b0; got_pc = '0; got_illegal = 1'b0;
    wr_n = -1; rd_n = -1;
    req_valid = 1'b1; req_op = op; req_csr_addr = addr; req_src = src;
    req_src_is_x0 = x0; req_pc = pc;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (req_ready) begin
      @(posedge clk);
      #1;
      acc_cyc   = cyc;
      req_valid = 1'b0;
      wr_start  = wr_total;
      rd_n      = rd_total;
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (resp_valid) begin
          got_lat = k; got_rd = resp_rd_data; got_redir = resp_redirect;
          got_pc = resp_redirect_pc; got_illegal = resp_illegal;
          break;
        end
      end
      wr_n = wr_total - wr_start;
      rd_n = rd_total - rd_n;
    end else begin
      req_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_csr_addr = '0;
    req_src = '0; req_src_is_x0 = 1'b0; req_pc = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", req_ready); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("[TB] FAIL reset_state got %0d want %0d", dut.state_q, IDLE); end
    checks++; if ({resp_valid, resp_redirect, resp_illegal, r_csr_en, w_csr_en} !== 5'b0) begin
      errors++; $display("[TB] FAIL reset_flags got %b want 00000", {resp_valid, resp_redirect, resp_illegal, r_csr_en, w_csr_en}); end
    checks++; if ({resp_rd_data, resp_redirect_pc, w_csr_data, w_csr_addr, r_csr_addr} !== '0) begin
      errors++; $display("[TB] FAIL reset_buses got %h want 0", {resp_rd_data, resp_redirect_pc, w_csr_data, w_csr_addr, r_csr_addr}); end
  endtask

  task automatic test_csrrw_mtvec();
    do_req(CSR_OP_RW, CSR_MTVEC, 32'h8000_0100, 1'b0, 32'h0);
    checks++; if (got_lat !== 3) begin errors++; $display("[TB] FAIL rw_latency got %0d want 3", got_lat); end
    checks++; if (got_rd !== 32'h0) begin errors++; $display("[TB] FAIL rw_rd got %h want 0", got_rd); end
    checks++; if (wr_n !== 1) begin errors++; $display("[TB] FAIL rw_wr_count got %0d want 1", wr_n); end
    checks++; if (wr_addr_log[wr_start % 16] !== CSR_MTVEC || wr_data_log[wr_start % 16] !== 32'h8000_0100) begin
      errors++; $display("[TB] FAIL rw_write got %h:%h want 305:80000100", wr_addr_log[wr_start % 16], wr_data_log[wr_start % 16]); end
    do_req(CSR_OP_RS, CSR_MTVEC, 32'h0, 1'b1, 32'h0);
    checks++; if (got_rd !== 32'h8000_0100) begin errors++; $display("[TB] FAIL rs_x0_rd got %h want 80000100", got_rd); end
    checks++; if (wr_n !== 0) begin errors++; $display("[TB] FAIL rs_x0_nowrite got %0d want 0", wr_n); end
    checks++; if (got_lat !== 3 || rd_n !== 1) begin errors++; $display("[TB] FAIL rs_x0_timing got lat %0d reads %0d want 3 1", got_lat, rd_n); end
  endtask

  task automatic test_csrrs_csrrc_mstatus();
    do_req(CSR_OP_RW, CSR_MSTATUS, 32'h1800, 1'b0, 32'h0);
    do_req(CSR_OP_RS, CSR_MSTATUS, 32'h8, 1'b0, 32'h0);
    checks++; if (got_rd !== 32'h1800) begin errors++; $display("[TB] FAIL rs_rd got %h want 1800", got_rd); end
    checks++; if (wr_n !== 1 || wr_data_log[wr_start % 16] !== 32'h1808) begin
      errors++; $display("[TB] FAIL rs_write got %0d:%h want 1:1808", wr_n, wr_data_log[wr_start % 16]); end
    do_req(CSR_OP_RC, CSR_MSTATUS, 32'h1000, 1'b0, 32'h0);
    checks++; if (got_rd !== 32'h1808) begin errors++; $display("[TB] FAIL rc_rd got %h want 1808", got_rd); end
    checks++; if (wr_n !== 1 || wr_data_log[wr_start % 16] !== 32'h0808) begin
      errors++; $display("[TB] FAIL rc_write got %0d:%h want 1:0808", wr_n, wr_data_log[wr_start % 16]); end
    do_req(CSR_OP_RC, CSR_MSTATUS, 32'h0, 1'b1, 32'h0);
    checks++; if (wr_n !== 0 || got_rd !== 32'h0808) begin
      errors++; $display("[TB] FAIL rc_x0 got writes %0d rd %h want 0 0808", wr_n, got_rd); end
    do_req(CSR_OP_RW, CSR_MCAUSE, 32'h0, 1'b1, 32'h0);
    checks++; if (wr_n !== 1 || wr_data_log[wr_start % 16] !== 32'h0) begin
      errors++; $display("[TB] FAIL rw_zero_write got %0d:%h want 1:0", wr_n, wr_data_log[wr_start % 16]); end
  endtask

  task automatic test_ecall();
    do_req(CSR_OP_ECALL, 12'h0, 32'h0, 1'b0, 32'h8000_0040);
    checks++; if (got_lat !== 4) begin errors++; $display("[TB] FAIL ecall_latency got %0d want 4", got_lat); end
    checks++; if (got_redir !== 1'b1 || got_pc !== 32'h8000_0100) begin
      errors++; $display("[TB] FAIL ecall_redirect got %b:%h want 1:80000100", got_redir, got_pc); end
    checks++; if (got_rd !== 32'h0 || got_illegal !== 1'b0) begin
      errors++; $display("[TB] FAIL ecall_rd got %h ill %b want 0 0", got_rd, got_illegal); end
    checks++; if (wr_n !== 2) begin errors++; $display("[TB] FAIL ecall_wr_count got %0d want 2", wr_n); end
    checks++; if (wr_addr_log[wr_start % 16] !== CSR_MEPC || wr_data_log[wr_start % 16] !== 32'h8000_0040) begin
      errors++; $display("[TB] FAIL ecall_mepc got %h:%h want 341:80000040", wr_addr_log[wr_start % 16], wr_data_log[wr_start % 16]); end
    checks++; if (wr_addr_log[(wr_start + 1) % 16] !== CSR_MCAUSE || wr_data_log[(wr_start + 1) % 16] !== 32'hb) begin
      errors++; $display("[TB] FAIL ecall_mcause got %h:%h want 342:b", wr_addr_log[(wr_start + 1) % 16], wr_data_log[(wr_start + 1) % 16]); end
    checks++; if (wr_cyc_log[(wr_start + 1) % 16] - wr_cyc_log[wr_start % 16] !== 1) begin
      errors++; $display("[TB] FAIL ecall_consecutive got %0d want 1", wr_cyc_log[(wr_start + 1) % 16] - wr_cyc_log[wr_start % 16]); end
  endtask

  task automatic test_mret();
    do_req(CSR_OP_MRET, 12'h0, 32'h0, 1'b0, 32'h0);
    checks++; if (got_lat !== 2) begin errors++; $display("[TB] FAIL mret_latency got %0d want 2", got_lat); end
    checks++; if (got_redir !== 1'b1 || got_pc !== 32'h8000_0040) begin
      errors++; $display("[TB] FAIL mret_redirect got %b:%h want 1:80000040", got_redir, got_pc); end
    checks++; if (wr_n !== 0 || got_rd !== 32'h0) begin
      errors++; $display("[TB] FAIL mret_nowrite got writes %0d rd %h want 0 0", wr_n, got_rd); end
  endtask

  task automatic test_illegal();
    int low;
    do_req(CSR_OP_RW, 12'h344, 32'hdead_beef, 1'b0, 32'h0);
    low = resp_valid ? (req_ready ? 0 : 1) : 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!req_ready) low++;
      else break;
    end
    checks++; if (got_lat !== 1 || got_illegal !== 1'b1) begin
      errors++; $display("[TB] FAIL illegal_addr got lat %0d ill %b want 1 1", got_lat, got_illegal); end
    checks++; if (wr_n !== 0 || rd_n !== 0 || got_rd !== 32'h0 || got_redir !== 1'b0) begin
      errors++; $display("[TB] FAIL illegal_quiet got w%0d r%0d rd %h redir %b want 0 0 0 0", wr_n, rd_n, got_rd, got_redir); end
    checks++; if (low !== 2) begin errors++; $display("[TB] FAIL illegal_ready_low got %0d want 2", low); end
    do_req(3'd5, CSR_MSTATUS, 32'h0, 1'b0, 32'h0);
    checks++; if (got_lat !== 1 || got_illegal !== 1'b1 || wr_n !== 0 || rd_n !== 0) begin
      errors++; $display("[TB] FAIL illegal_op got lat %0d ill %b w%0d r%0d want 1 1 0 0", got_lat, got_illegal, wr_n, rd_n); end
  endtask

  task automatic test_back_to_back();
    int first_acc;
    do_req(CSR_OP_RW, CSR_MEPC, 32'h0000_0011, 1'b0, 32'h0);
    first_acc = acc_cyc;
    do_req(CSR_OP_RS, CSR_MEPC, 32'h0, 1'b1, 32'h0);
    checks++; if (got_rd !== 32'h11) begin errors++; $display("[TB] FAIL raw_rd got %h want 11", got_rd); end
    checks++; if (acc_cyc - first_acc !== 5) begin errors++; $display("[TB] FAIL b2b_gap got %0d want 5", acc_cyc - first_acc); end
  endtask

  task automatic test_reset_mid_ecall();
    int waited;
    do_req(CSR_OP_RW, CSR_MCAUSE, 32'h1234, 1'b0, 32'h0);
    checks++; if (got_rd !== 32'hb) begin errors++; $display("[TB] FAIL pre_mcause_rd got %h want b", got_rd); end
    req_valid = 1'b1; req_op = CSR_OP_ECALL; req_csr_addr = '0; req_src = '0;
    req_src_is_x0 = 1'b0; req_pc = 32'h0000_0040;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (w_csr_en !== 1'b1 || w_csr_addr !== CSR_MCAUSE) begin
      errors++; $display("[TB] FAIL tcause_reached got %b:%h want 1:342", w_csr_en, w_csr_addr); end
    rst = 1'b1;
    #1;
    checks++; if (dut.state_q !== IDLE || req_ready !== 1'b1 || w_csr_en !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_now got st %0d rdy %b wen %b want %0d 1 0", dut.state_q, req_ready, w_csr_en, IDLE); end
    @(negedge clk);
    checks++; if (dut.state_q !== IDLE || req_ready !== 1'b1 || w_csr_en !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_next got st %0d rdy %b wen %b want %0d 1 0", dut.state_q, req_ready, w_csr_en, IDLE); end
    rst = 1'b0;
    checks++; if (rf_mcause !== 32'h1234 || rf_mepc !== 32'h40) begin
      errors++; $display("[TB] FAIL abort_rf got mcause %h mepc %h want 1234 40", rf_mcause, rf_mepc); end
    @(negedge clk);
    do_req(CSR_OP_RS, CSR_MCAUSE, 32'h0, 1'b1, 32'h0);
    checks++; if (got_rd !== 32'h1234 || wr_n !== 0) begin
      errors++; $display("[TB] FAIL post_abort_rd got %h w%0d want 1234 0", got_rd, wr_n); end
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_csrrw_mtvec();
    test_csrrs_csrrc_mstatus();
    test_ecall();
    test_mret();
    test_illegal();
    test_back_to_back();
    test_reset_mid_ecall();
    @(negedge clk);
    checks++; if (viol !== 0) begin errors++; $display("[TB] FAIL port_exclusive got %0d want 0", viol); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
